z_pwm: RTL and testbench
========================

# z_pwm

Parameterised pulse-width modulator that turns a per-period duty word into a single-bit rectangular wave. A phase counter advances by a programmable step each enabled clock and wraps at a programmable period. The block emits a one-cycle `end_tick` at each wrap, so an upstream sequencer (such as a sine-table walker) can present the next duty value. It sits between a sample source and an output pin or filter.

## Interface
- `pWIDTH`, 10: width of the phase counter and of `cyc_duty`.
- `pPERIOD`, 210: phase counts per PWM period. Constraints: pPERIOD ≤ 2^pWIDTH, pINC ≤ pPERIOD.
- `pINC`, 5: phase increment per enabled clock. Constraint: pINC ≥ 1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high (name kept per codebase convention).
- `en`  in  1  count/output enable.
- `cyc_duty`  in  pWIDTH  duty threshold in phase counts.
- `wave`  out  1  registered PWM output.
- `end_tick`  out  1  registered one-cycle pulse marking the period wrap.

## Operation
- Registers:
  - `cnt`: pWIDTH-bit phase counter.
  - `duty_q`: pWIDTH-bit active duty.
  - `wave` and `end_tick`: registered outputs.
- Reset (rst_n=1, async) forces `cnt`=0, `duty_q`=0, `wave`=0 and `end_tick`=0. These values hold while reset is asserted, including when it is asserted mid-period.
- Each rising clock with en=1:
  - If `cnt` ≥ pPERIOD−pINC (wrap case): `cnt` ← 0, `end_tick` ← 1, `duty_q` ← `cyc_duty`.
  - Otherwise: `cnt` ← `cnt`+pINC, `end_tick` ← 0.
  - In both cases `wave` ← (`cnt` < `duty_q`). The compare uses the pre-update values and is unsigned, full pWIDTH width.
- Each rising clock with en=0: `cnt` and `duty_q` hold, `wave` ← 0, `end_tick` ← 0. Counting resumes from the held phase when en returns to 1.
- Phase sequence: 0, pINC, 2·pINC, … up to the last value below pPERIOD. This gives N = ceil(pPERIOD/pINC) clocks per period; N = 42 at the defaults.
- High time per period = min(ceil(duty_q/pINC), N) clocks.
  - duty_q = 0 → wave constantly low.
  - duty_q ≥ pPERIOD → wave constantly high; no end-of-period low cycle.
- The counter never exceeds pPERIOD−1, so no overflow arithmetic is needed.

## Timing
- `wave` lags the `cnt` value that produced it by one clock.
- `end_tick` is high for exactly one clock per period. It is asserted in the cycle after `cnt` reaches its last phase, i.e. coincident with `cnt`=0.
- With ZPWM_DUTY_LATCH_EN defined, a duty value sampled at a wrap edge first affects `wave` one clock after that edge. That is the first phase-0 output cycle of the new period.
- The upstream source must present the new `cyc_duty` before the next wrap edge. It may update on the cycle `end_tick` is seen high, which gives N−1 clocks of margin.
- After reset release the first period runs with `duty_q`=0, so `wave` stays low until after the first `end_tick`.
- en deasserted on the same edge as a wrap condition: en wins, with no wrap and no tick.

## Configuration
- `ZPWM_DUTY_LATCH_EN` defined: `duty_q` loads `cyc_duty` only on wrap edges, as described above, giving glitch-free periods.
- Not defined: `duty_q` is bypassed and the compare uses live `cyc_duty` every cycle. Duty changes take effect on the next clock, mid-period included, and the first period after reset follows `cyc_duty` directly.
- All other behaviour is identical in both builds.

## Test plan
- Defaults, latch enabled, en=1, `cyc_duty`=105 constant → after the first `end_tick`, every period is 42 clocks with `wave` high 21 clocks, then low 21; `end_tick` period is 42 clocks.
- `cyc_duty`=0 → `wave` always 0. `cyc_duty`=210 and `cyc_duty`=1023 → `wave` continuously 1 after the first tick; `end_tick` continues every 42 clocks.
- `cyc_duty`=1 → 1 high clock per period; `cyc_duty`=6 → 2 high clocks.
- Change `cyc_duty` from 50 to 150 mid-period (latch enabled) → the current period keeps 10 high clocks and the next period has 30.
- Drop en for 7 clocks mid-period → `wave`=0 and `end_tick`=0 throughout, `cnt` frozen. The affected period stretches to 49 clocks.
- Assert rst_n for 1 ns mid-period, asynchronously between edges → all outputs are 0 immediately. After release, 42 clocks elapse before the first `end_tick`, and `wave` stays low during that interval.

Source files
------------

// File: rtl/z_pwm.sv
// rtl/z_pwm.sv - phase-accumulator PWM with per-period end tick
// Optional feature: define ZPWM_DUTY_LATCH_EN to latch cyc_duty at each period wrap.
module z_pwm #(
    parameter int pWIDTH  = 10,
    parameter int pPERIOD = 210,
    parameter int pINC    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [pWIDTH-1:0] cyc_duty,
    output logic              wave,
    output logic              end_tick
);

    localparam logic [pWIDTH-1:0] WRAP_AT = pWIDTH'(pPERIOD - pINC);
    localparam logic [pWIDTH-1:0] STEP    = pWIDTH'(pINC);

    logic [pWIDTH-1:0] cnt;
    logic [pWIDTH-1:0] duty_cmp;
    logic              wrap;

    assign wrap = (cnt >= WRAP_AT);

`ifdef ZPWM_DUTY_LATCH_EN
    logic [pWIDTH-1:0] duty_q;

    // Duty only changes on a wrap edge so each period is glitch-free.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            duty_q <= '0;
        end else if (en && wrap) begin
            duty_q <= cyc_duty;
        end
    end

    assign duty_cmp = duty_q;
`else
    assign duty_cmp = cyc_duty;
`endif

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt      <= '0;
            wave     <= 1'b0;
            end_tick <= 1'b0;
        end else if (en) begin
            wave <= (cnt < duty_cmp);
            if (wrap) begin
                cnt      <= '0;
                end_tick <= 1'b1;
            end else begin
                cnt      <= cnt + STEP;
                end_tick <= 1'b0;
            end
        end else begin
            wave     <= 1'b0;
            end_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_z_pwm.sv
// tb/tb_z_pwm.sv - directed self-checking bench for z_pwm
`timescale 1ns/100ps
module tb_z_pwm;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       en       = 1'b0;
    logic [9:0] cyc_duty = '0;
    logic       wave;
    logic       end_tick;

    int checks   = 0;
    int failures = 0;

`ifdef ZPWM_DUTY_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    z_pwm #(.pWIDTH(10), .pPERIOD(210), .pINC(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cyc_duty (cyc_duty),
        .wave     (wave),
        .end_tick (end_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sync_tick();
        for (int i = 0; i < 200; i++) begin
            if (end_tick) break;
            step();
        end
    endtask

    // Cycles from the current sample to the next end_tick, with wave-high count; len=-1 on timeout.
    task automatic measure(output int len, output int high);
        high = 0;
        len  = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (wave) high++;
            if (end_tick) begin
                len = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int len, high;
        rst_n = 1'b1; en = 1'b1; cyc_duty = 10'd105;
        step(); step();
        checks++; if (wave !== 1'b0) begin failures++; $display("FAIL reset_wave got=%b exp=0", wave); end
        checks++; if (end_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", end_tick); end
        checks++; if (dut.cnt !== 10'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt); end
        rst_n = 1'b0;
        measure(len, high);
        checks++; if (len !== 42) begin failures++; $display("FAIL first_period_len got=%0d exp=42", len); end
        checks++; if (high !== (LATCH ? 0 : 21)) begin failures++; $display("FAIL first_period_high got=%0d exp=%0d", high, LATCH ? 0 : 21); end
    endtask

    task automatic test_duty(input logic [9:0] d, input int exp_high);
        int len, high;
        cyc_duty = d;
        sync_tick();
        measure(len, high);
        measure(len, high);
        checks++; if (len !== 42) begin failures++; $display("FAIL duty%0d_len got=%0d exp=42", d, len); end
        checks++; if (high !== exp_high) begin failures++; $display("FAIL duty%0d_high got=%0d exp=%0d", d, high, exp_high); end
    endtask

    task automatic test_mid_change();
        int len, high;
        cyc_duty = 10'd50;
        sync_tick();
        measure(len, high);
        measure(len, high);
        high = 0; len = -1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (wave) high++;
            if (i == 20) cyc_duty = 10'd150;
            if (end_tick) begin len = i; break; end
        end
        checks++; if (len !== 42) begin failures++; $display("FAIL change_len got=%0d exp=42", len); end
        checks++; if (high !== (LATCH ? 10 : 20)) begin failures++; $display("FAIL change_cur_high got=%0d exp=%0d", high, LATCH ? 10 : 20); end
        measure(len, high);
        checks++; if (high !== 30) begin failures++; $display("FAIL change_next_high got=%0d exp=30", high); end
    endtask

    task automatic test_en_pause();
        int len, high, high0, wave_seen, tick_seen;
        cyc_duty = 10'd105;
        sync_tick();
        measure(len, high);
        measure(len, high);
        high0 = 0;
        for (int i = 0; i < 10; i++) begin step(); if (wave) high0++; end
        en = 1'b0;
        wave_seen = 0; tick_seen = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (wave !== 1'b0) wave_seen++;
            if (end_tick !== 1'b0) tick_seen++;
        end
        checks++; if (wave_seen !== 0) begin failures++; $display("FAIL pause_wave got=%0d nonzero samples exp=0", wave_seen); end
        checks++; if (tick_seen !== 0) begin failures++; $display("FAIL pause_tick got=%0d nonzero samples exp=0", tick_seen); end
        checks++; if (dut.cnt !== 10'd50) begin failures++; $display("FAIL pause_cnt got=%0d exp=50", dut.cnt); end
        en = 1'b1;
        measure(len, high);
        checks++; if (len + 17 !== 49) begin failures++; $display("FAIL pause_period_len got=%0d exp=49", len + 17); end
        checks++; if (high + high0 !== 21) begin failures++; $display("FAIL pause_period_high got=%0d exp=21", high + high0); end
    endtask

    task automatic test_en_on_wrap();
        int len, high;
        sync_tick();
        for (int i = 0; i < 41; i++) step();
        checks++; if (dut.cnt !== 10'd205) begin failures++; $display("FAIL prewrap_cnt got=%0d exp=205", dut.cnt); end
        en = 1'b0;
        step();
        checks++; if (end_tick !== 1'b0) begin failures++; $display("FAIL enwrap_tick got=%b exp=0", end_tick); end
        checks++; if (dut.cnt !== 10'd205) begin failures++; $display("FAIL enwrap_cnt got=%0d exp=205", dut.cnt); end
        en = 1'b1;
        step();
        checks++; if (end_tick !== 1'b1) begin failures++; $display("FAIL enwrap_resume_tick got=%b exp=1", end_tick); end
        measure(len, high);
    endtask

    task automatic test_async_reset();
        int len, high;
        cyc_duty = 10'd105;
        sync_tick();
        measure(len, high);
        measure(len, high);
        for (int i = 0; i < 5; i++) step();
        checks++; if (wave !== 1'b1) begin failures++; $display("FAIL prereset_wave got=%b exp=1", wave); end
        #2;
        rst_n = 1'b1;
        #0.5;
        checks++; if (wave !== 1'b0) begin failures++; $display("FAIL async_wave got=%b exp=0", wave); end
        checks++; if (end_tick !== 1'b0) begin failures++; $display("FAIL async_tick got=%b exp=0", end_tick); end
        checks++; if (dut.cnt !== 10'd0) begin failures++; $display("FAIL async_cnt got=%0d exp=0", dut.cnt); end
        #0.5;
        rst_n = 1'b0;
        measure(len, high);
        checks++; if (len !== 42) begin failures++; $display("FAIL postreset_len got=%0d exp=42", len); end
        checks++; if (high !== (LATCH ? 0 : 21)) begin failures++; $display("FAIL postreset_high got=%0d exp=%0d", high, LATCH ? 0 : 21); end
    endtask

    initial begin
        test_reset();
        test_duty(10'd105, 21);
        test_duty(10'd0, 0);
        test_duty(10'd210, 42);
        test_duty(10'd1023, 42);
        test_duty(10'd1, 1);
        test_duty(10'd6, 2);
        test_mid_change();
        test_en_pause();
        test_en_on_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
